spawn_scheduler: RTL and testbench
==================================

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 Parameter INTERVAL, default 4: number of tick pulses between spawn draws; legal range 1..15.
REQ-002 Parameter DEPTH, default 4: pending-spawn FIFO depth; legal values 2, 4, 8.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port rand_in  input  4  random value from the game random source; valid draws are 1..8.
REQ-006 Port tick  input  1  one-clk-wide game timebase pulse.
REQ-007 Port enable  input  1  scheduling enable; 0 freezes the interval counter.
REQ-008 Port spawn_valid  output  1  FIFO head holds a spawn.
REQ-009 Port spawn_lane  output  3  lane index 0..7 (draw minus 1) of the FIFO head.
REQ-010 Port spawn_ready  input  1  consumer accepts the head this cycle.
REQ-011 Port pending  output  4  current FIFO occupancy, 0..DEPTH.
REQ-012 Port overflow  output  1  sticky flag: a draw was dropped because the FIFO was full.

Function
REQ-013 States: IDLE, COUNT, DRAW.
- IDLE -> COUNT when enable=1.
- COUNT/DRAW -> IDLE when enable=0; interval counter cleared.
REQ-014 COUNT: interval counter increments on tick.
- tick arriving with counter = INTERVAL-1 clears the counter and enters DRAW the next cycle.
REQ-015 DRAW: rand_in sampled every cycle until valid.
- rand_in in 1..8: lane = rand_in-1 pushed to FIFO that cycle; return to COUNT.
- rand_in 0 or 9..15: no push; remain in DRAW and resample next cycle.
REQ-016 Ticks arriving while in DRAW are ignored (not counted).
REQ-017 Push latency: a pushed lane appears on spawn_lane with spawn_valid=1 on the first cycle after the push edge if the FIFO was empty.
REQ-018 Pop on spawn_valid && spawn_ready; spawn_lane/spawn_valid update the next cycle.
REQ-019 spawn_valid=0 whenever pending=0; spawn_lane holds its last value when not valid.
REQ-020 Push while pending=DEPTH and no pop in the same cycle: draw dropped, overflow set, state returns to COUNT.
REQ-021 Simultaneous push and pop at full: both performed, occupancy unchanged, no overflow.
REQ-022 Simultaneous push and pop at empty: push takes effect, pop ignored (spawn_valid was 0).
REQ-023 FIFO pointers wrap modulo DEPTH; ordering strictly first-in first-out.
REQ-024 overflow clears only on rst.
REQ-025 enable=0 does not stop the FIFO draining.

Reset
REQ-026 On rst: state IDLE, interval counter 0, FIFO emptied, pending=0, spawn_valid=0, spawn_lane=0, overflow=0, last-lane register 0.
REQ-027 rst asserted mid-DRAW or mid-handshake discards all pending spawns; no spawn emitted after rst deasserts until a new draw completes.

Configuration
REQ-028 Macro SPAWN_NO_REPEAT_EN:
- Defined: a drawn lane equal to the last pushed lane is replaced by (lane+1) mod 8 before the push; the last-lane register updates on every push, not on drops.
- Undefined: lanes are pushed unmodified; repeats are allowed.

Verification
REQ-029 INTERVAL=4, enable=1, rand_in=3, 4 ticks -> one push, spawn_lane=2, spawn_valid=1, pending=1.
REQ-030 In DRAW, rand_in=0 for 3 cycles, then 8 -> no push for 3 cycles; on the 4th cycle lane 7 is pushed.
REQ-031 spawn_ready=0, DEPTH=4, 5 draws -> pending=4, overflow=1; lanes pop in push order once ready=1.
REQ-032 Full FIFO, push and pop in the same cycle -> pending stays 4, overflow stays 0.
REQ-033 SPAWN_NO_REPEAT_EN defined, two draws of rand_in=8 -> lanes 7 then 0; macro undefined -> lanes 7 then 7.
REQ-034 rst pulse with pending=3 during DRAW -> pending=0, spawn_valid=0, state IDLE, overflow=0.

Source files
------------

// File: rtl/spawn_scheduler.sv
// Spawn scheduler: draws a lane every INTERVAL ticks and queues it in a small FIFO.
// Optional macro SPAWN_NO_REPEAT_EN bumps a lane that repeats the last pushed lane.
module spawn_scheduler #(
  parameter int INTERVAL = 4,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rand_in,
  input  logic       tick,
  input  logic       enable,
  output logic       spawn_valid,
  output logic [2:0] spawn_lane,
  input  logic       spawn_ready,
  output logic [3:0] pending,
  output logic       overflow
);

  localparam int PW = (DEPTH <= 2) ? 1 : (DEPTH <= 4) ? 2 : 3;

  typedef enum logic [1:0] {IDLE, COUNT, DRAW} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      mem_q [DEPTH];
  logic [2:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d, rd_next;
  logic [3:0]      count_q, count_d;
  logic [2:0]      lane_q, lane_d;
  logic            ovf_q, ovf_d;
  logic            draw_ok, push_req, push, pop, full;
  logic [2:0]      raw_lane, push_lane;
`ifdef SPAWN_NO_REPEAT_EN
  logic [2:0]      last_q, last_d;
`endif

  always_comb begin
    draw_ok  = (rand_in >= 4'd1) && (rand_in <= 4'd8);
    raw_lane = 3'(rand_in - 4'd1);
    push_lane = raw_lane;
`ifdef SPAWN_NO_REPEAT_EN
    if (raw_lane == last_q) push_lane = raw_lane + 3'd1;
`endif
    full     = (count_q == 4'(DEPTH));
    pop      = (count_q != 4'd0) && spawn_ready;
    push_req = (state_q == DRAW) && enable && draw_ok;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = push_req && (!full || pop);
    rd_next  = rd_q + PW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (tick) begin
          if (cnt_q == 4'(INTERVAL - 1)) begin
            cnt_d   = 4'd0;
            state_d = DRAW;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DRAW: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (draw_ok) begin
          state_d = COUNT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + 4'(push) - 4'(pop);
    lane_d  = lane_q;
    ovf_d   = ovf_q | (push_req && !push);
`ifdef SPAWN_NO_REPEAT_EN
    last_d  = last_q;
    if (push) last_d = push_lane;
`endif
    if (push) begin
      mem_d[wr_q] = push_lane;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    // The output lane register tracks whatever will be the head after this edge.
    if (push && ((count_q == 4'd0) || (pop && count_q == 4'd1)))
      lane_d = push_lane;
    else if (pop && count_q > 4'd1)
      lane_d = mem_q[rd_next];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= 4'd0;
      lane_q  <= 3'd0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'd0;
`ifdef SPAWN_NO_REPEAT_EN
      last_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef SPAWN_NO_REPEAT_EN
      last_q  <= last_d;
`endif
    end
  end

  assign spawn_valid = (count_q != 4'd0);
  assign spawn_lane  = lane_q;
  assign pending     = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler with a lane scoreboard and a small occupancy model.
// Honours SPAWN_NO_REPEAT_EN in its lane model when the macro is defined.
module tb_spawn_scheduler;

  localparam int INTERVAL = 4;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rand_in = 4'd0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic       spawn_valid;
  logic [2:0] spawn_lane;
  logic       spawn_ready = 1'b0;
  logic [3:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] sb [$];
  logic [3:0] m_count = 4'd0;
  logic       m_ovf   = 1'b0;
  logic [2:0] m_last  = 3'd0;
  logic [2:0] m_hold  = 3'd0;

  spawn_scheduler #(.INTERVAL(INTERVAL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .tick(tick), .enable(enable),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model_lane(input logic [3:0] rv);
    logic [2:0] l;
    l = 3'(rv - 4'd1);
`ifdef SPAWN_NO_REPEAT_EN
    if (l == m_last) l = l + 3'd1;
`endif
    return l;
  endfunction

  task automatic model_draw(input logic [3:0] rv);
    logic [2:0] l;
    if (m_count == 4'(DEPTH)) begin
      m_ovf = 1'b1;
    end else begin
      l = model_lane(rv);
      sb.push_back(l);
      m_last = l;
      m_count++;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 4'd0;
    m_ovf   = 1'b0;
    m_last  = 3'd0;
    m_hold  = 3'd0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  // The final tick edge enters DRAW; the following edge samples rand_in.
  task automatic apply_stimulus(input logic [3:0] rv);
    rand_in = rv;
    do_ticks(INTERVAL);
    model_draw(rv);
  endtask

  task automatic check_state(input string tag);
    check_output({tag, ".pending"}, 8'(pending), 8'(m_count));
    check_output({tag, ".valid"}, 8'(spawn_valid), 8'(m_count != 4'd0));
    check_output({tag, ".overflow"}, 8'(overflow), 8'(m_ovf));
    if (sb.size() > 0) check_output({tag, ".lane"}, 8'(spawn_lane), 8'(sb[0]));
    else check_output({tag, ".hold"}, 8'(spawn_lane), 8'(m_hold));
  endtask

  task automatic drain(input string tag);
    spawn_ready = 1'b1;
    for (int i = 0; i < 16 && sb.size() > 0; i++) begin
      check_output({tag, ".drain_valid"}, 8'(spawn_valid), 8'd1);
      check_output({tag, ".drain_lane"}, 8'(spawn_lane), 8'(sb[0]));
      cyc();
      m_hold = sb.pop_front();
      m_count--;
    end
    spawn_ready = 1'b0;
    check_state({tag, ".drained"});
  endtask

  initial begin
    cyc();
    cyc();
    check_state("reset");
    check_output("reset.lane0", 8'(spawn_lane), 8'd0);
    rst    = 1'b0;
    enable = 1'b1;
    cyc();

    apply_stimulus(4'd3);
    check_state("basic");
    check_output("basic.lane2", 8'(spawn_lane), 8'd2);
    drain("basic");
    check_output("basic.hold2", 8'(spawn_lane), 8'd2);

    // Invalid draws keep the FSM in DRAW; ticks there must not count.
    rand_in = 4'd0;
    do_ticks(INTERVAL);
    check_state("resample1");
    rand_in = 4'd15;
    tick = 1'b1;
    cyc();
    rand_in = 4'd9;
    cyc();
    tick = 1'b0;
    check_state("resample3");
    rand_in = 4'd8;
    cyc();
    model_draw(4'd8);
    check_state("resample_push");
    rand_in = 4'd5;
    do_ticks(INTERVAL - 1);
    check_state("counter_cleared");
    do_ticks(1);
    model_draw(4'd5);
    check_state("after_resample_draw");
    drain("resample");

    apply_stimulus(4'd8);
    apply_stimulus(4'd8);
    check_state("repeat");
    drain("repeat");

    for (int v = 1; v <= 5; v++) begin
      apply_stimulus(4'(v));
      check_state("fill");
    end
    check_output("full.pending", 8'(pending), 8'(DEPTH));
    check_output("full.overflow", 8'(overflow), 8'd1);
    drain("overflow");

    // Refill to three entries with overflow still sticky, then reset in DRAW.
    for (int v = 2; v <= 4; v++) apply_stimulus(4'(v));
    check_state("pre_reset");
    rand_in = 4'd0;
    do_ticks(INTERVAL);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state("midreset");
    check_output("midreset.lane0", 8'(spawn_lane), 8'd0);
    cyc();
    rst = 1'b0;
    spawn_ready = 1'b1;
    rand_in = 4'd5;
    cyc();
    check_state("post_reset_idle");
    spawn_ready = 1'b0;
    do_ticks(INTERVAL - 1);
    check_state("post_reset_count");
    do_ticks(1);
    model_draw(4'd5);
    check_state("post_reset_draw");
    drain("post_reset");

    // Full FIFO with push and pop on the same edge.
    for (int v = 1; v <= 4; v++) apply_stimulus(4'(v));
    check_state("full2");
    rand_in = 4'd6;
    do_ticks(INTERVAL - 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    spawn_ready = 1'b1;
    check_output("simul.head", 8'(spawn_lane), 8'(sb[0]));
    cyc();
    spawn_ready = 1'b0;
    m_hold = sb.pop_front();
    m_count--;
    model_draw(4'd6);
    check_output("simul.pending", 8'(pending), 8'(DEPTH));
    check_output("simul.overflow", 8'(overflow), 8'd0);
    check_state("simul");
    drain("simul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
